// File: rtl/pkt_ingress_tagger_pkg.sv
// rtl/pkt_ingress_tagger_pkg.sv - shared types and sizing for the ingress tagger
package my_struct_s;

  localparam int PKT_AWIDTH  = 9;
  localparam int PKT_NUM     = 2 ** PKT_AWIDTH;
  localparam int FLIT_AWIDTH = 5;
  localparam int MAX_FLITS   = 24;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SOP,
    ST_BODY
  } state_t;

  // flits needs one bit more than a flit index so a full slot can be counted
  typedef struct packed {
    logic [7:0]             rsvd;
    logic [FLIT_AWIDTH:0]   flits;
    logic [PKT_AWIDTH-1:0]  pktID;
  } metadata_t;

endpackage

// File: rtl/pkt_ingress_tagger_free_id_fifo.sv
// rtl/pkt_ingress_tagger_free_id_fifo.sv - show-ahead FIFO of free packet IDs
module free_id_fifo #(
  parameter int DEPTH = 512,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pkt_ingress_tagger.sv
// rtl/pkt_ingress_tagger.sv - tags ingress frames with a buffer slot ID and emits header beat plus metadata
module pkt_ingress_tagger
  import my_struct_s::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [511:0]                      in_pkt_data,
  input  logic                              in_pkt_valid,
  input  logic                              in_pkt_sop,
  input  logic                              in_pkt_eop,
  input  logic [5:0]                        in_pkt_empty,
  output logic                              in_pkt_ready,
  output logic [511:0]                      out_pkt_data,
  output logic                              out_pkt_valid,
  output logic                              out_pkt_sop,
  output logic                              out_pkt_eop,
  output logic [5:0]                        out_pkt_empty,
  output metadata_t                         out_meta_data,
  output logic                              out_meta_valid,
  input  logic                              out_ready,
  output logic                              pktbuf_wr_en,
  output logic [PKT_AWIDTH+FLIT_AWIDTH-1:0] pktbuf_wr_addr,
  output logic [511:0]                      pktbuf_wr_data,
  input  logic                              rel_valid,
  input  logic [PKT_AWIDTH-1:0]             rel_pktID,
  output logic [31:0]                       stat_pkts,
  output logic [31:0]                       stat_trunc
);

  localparam logic [FLIT_AWIDTH:0] MAX_F = (FLIT_AWIDTH+1)'(MAX_FLITS);

  state_t                 state, state_nxt;
  logic [PKT_AWIDTH-1:0]  init_cnt, cur_id, id_eff, fifo_head, fifo_push_data;
  logic                   fifo_empty, fifo_full, fifo_push;
  logic [FLIT_AWIDTH:0]   flit_idx, idx_eff, flits_eop;
  logic                   trunc_flag, trunc_eff, beat_trunc;
  logic [511:0]           hdr_data;
  logic                   accept, start_new, in_beat, close_eop, close_sop;
  metadata_t              meta_nxt;

  assign fifo_push      = (state == ST_INIT) | rel_valid;
  assign fifo_push_data = (state == ST_INIT) ? init_cnt : rel_pktID;

  free_id_fifo #(.DEPTH(PKT_NUM), .DW(PKT_AWIDTH)) u_free_ids (
    .clk(clk), .rst(rst), .push(fifo_push), .push_data(fifo_push_data),
    .pop(start_new), .head(fifo_head), .empty(fifo_empty), .full(fifo_full)
  );

  assign in_pkt_ready = (state != ST_INIT) && (state == ST_BODY || !fifo_empty)
                        && (!out_pkt_valid || out_ready);
  assign accept       = in_pkt_valid & in_pkt_ready;

  // A sop inside BODY closes the open packet; it opens a new one only when an ID is free
  // and the output register is not also needed for a single-flit close in the same cycle.
  assign start_new  = accept & in_pkt_sop & ~fifo_empty & ((state == ST_SOP) | ~in_pkt_eop);
  assign close_sop  = accept & (state == ST_BODY) & in_pkt_sop;
  assign in_beat    = start_new | (accept & (state == ST_BODY) & ~in_pkt_sop);
  assign close_eop  = in_beat & in_pkt_eop;

  assign id_eff     = start_new ? fifo_head : cur_id;
  assign idx_eff    = start_new ? '0 : flit_idx;
  assign trunc_eff  = start_new ? 1'b0 : trunc_flag;
  assign beat_trunc = (idx_eff >= MAX_F);
  assign flits_eop  = beat_trunc ? MAX_F : idx_eff + 1'b1;

  assign pktbuf_wr_en   = in_beat & ~beat_trunc;
  assign pktbuf_wr_addr = pktbuf_wr_en ? {id_eff, idx_eff[FLIT_AWIDTH-1:0]} : '0;
  assign pktbuf_wr_data = pktbuf_wr_en ? in_pkt_data : '0;

  assign out_pkt_sop    = out_pkt_valid;
  assign out_pkt_eop    = out_pkt_valid;
  assign out_meta_valid = out_pkt_valid;

  always_comb begin
    meta_nxt       = '0;
    meta_nxt.pktID = close_sop ? cur_id : id_eff;
    meta_nxt.flits = close_sop ? flit_idx : flits_eop;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == PKT_AWIDTH'(PKT_NUM - 1)) state_nxt = ST_SOP;
      ST_SOP:  if (start_new && !in_pkt_eop) state_nxt = ST_BODY;
      ST_BODY: begin
        if (close_eop)      state_nxt = ST_SOP;
        else if (close_sop) state_nxt = start_new ? ST_BODY : ST_SOP;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt      <= '0;
      cur_id        <= '0;
      flit_idx      <= '0;
      trunc_flag    <= 1'b0;
      hdr_data      <= '0;
      out_pkt_valid <= 1'b0;
      out_pkt_data  <= '0;
      out_pkt_empty <= '0;
      out_meta_data <= '0;
      stat_pkts     <= '0;
      stat_trunc    <= '0;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      if (start_new) begin
        cur_id   <= fifo_head;
        hdr_data <= in_pkt_data;
      end
      if (in_beat) begin
        flit_idx   <= beat_trunc ? MAX_F : idx_eff + 1'b1;
        trunc_flag <= trunc_eff | beat_trunc;
      end
      if (close_eop || close_sop) begin
        out_pkt_valid <= 1'b1;
        out_pkt_data  <= (close_eop && start_new) ? in_pkt_data : hdr_data;
        out_pkt_empty <= (close_eop && start_new) ? in_pkt_empty : 6'd0;
        out_meta_data <= meta_nxt;
        stat_pkts     <= stat_pkts + 32'd1;
        if (close_sop ? trunc_flag : (trunc_eff | beat_trunc))
          stat_trunc <= stat_trunc + 32'd1;
      end else if (out_ready) begin
        out_pkt_valid <= 1'b0;
      end
    end
  end

  // IDs are unique, so a release into a full free list means a double release upstream
  a_no_double_release: assert property (@(posedge clk) disable iff (rst)
    !(rel_valid && fifo_full && !start_new));

endmodule

// File: tb/tb_pkt_ingress_tagger.sv
// tb/tb_pkt_ingress_tagger.sv - scoreboard bench for pkt_ingress_tagger
module tb_pkt_ingress_tagger;
  import my_struct_s::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] in_pkt_data = '0;
  logic         in_pkt_valid = 1'b0, in_pkt_sop = 1'b0, in_pkt_eop = 1'b0;
  logic [5:0]   in_pkt_empty = '0;
  logic         in_pkt_ready;
  logic [511:0] out_pkt_data;
  logic         out_pkt_valid, out_pkt_sop, out_pkt_eop;
  logic [5:0]   out_pkt_empty;
  metadata_t    out_meta_data;
  logic         out_meta_valid;
  logic         out_ready = 1'b1;
  logic         pktbuf_wr_en;
  logic [13:0]  pktbuf_wr_addr;
  logic [511:0] pktbuf_wr_data;
  logic         rel_valid = 1'b0;
  logic [8:0]   rel_pktID = '0;
  logic [31:0]  stat_pkts, stat_trunc;

  always #5 clk = ~clk;

  pkt_ingress_tagger dut (
    .clk(clk), .rst(rst),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_sop(in_pkt_sop),
    .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
    .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid), .out_pkt_sop(out_pkt_sop),
    .out_pkt_eop(out_pkt_eop), .out_pkt_empty(out_pkt_empty), .out_meta_data(out_meta_data),
    .out_meta_valid(out_meta_valid), .out_ready(out_ready),
    .pktbuf_wr_en(pktbuf_wr_en), .pktbuf_wr_addr(pktbuf_wr_addr), .pktbuf_wr_data(pktbuf_wr_data),
    .rel_valid(rel_valid), .rel_pktID(rel_pktID), .stat_pkts(stat_pkts), .stat_trunc(stat_trunc)
  );

  typedef struct { logic [13:0] addr; logic [511:0] data; } wexp_t;
  typedef struct { logic [511:0] data; logic [5:0] empty; metadata_t meta; } oexp_t;

  wexp_t wq[$];
  oexp_t oq[$];
  wexp_t we;
  oexp_t oe;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk(input int seq, input int beat);
    logic [15:0] s, b;
    s = seq[15:0];
    b = beat[15:0];
    return {16{s, b}};
  endfunction

  function automatic metadata_t mmeta(input logic [8:0] id, input logic [5:0] flits);
    metadata_t m;
    m = '0;
    m.pktID = id;
    m.flits = flits;
    return m;
  endfunction

  task automatic push_w(input logic [8:0] id, input int idx, input logic [511:0] d);
    wexp_t e;
    logic [4:0] i5;
    i5 = idx[4:0];
    e.addr = {id, i5};
    e.data = d;
    wq.push_back(e);
  endtask

  task automatic push_o(input logic [511:0] d, input logic [5:0] emp, input logic [8:0] id,
                        input logic [5:0] flits);
    oexp_t e;
    e.data = d;
    e.empty = emp;
    e.meta = mmeta(id, flits);
    oq.push_back(e);
  endtask

  task automatic set_beat(input logic [511:0] d, input logic s, input logic e, input logic [5:0] emp);
    in_pkt_data = d; in_pkt_sop = s; in_pkt_eop = e; in_pkt_empty = emp; in_pkt_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_pkt_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("accept_before_timeout", in_pkt_ready, 1'b1);
    @(posedge clk); #1;
    in_pkt_valid = 1'b0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int seq, input logic [5:0] emp, input logic [8:0] id);
    push_o(mk(seq, 0), (n == 1) ? emp : 6'd0, id, (n > MAX_FLITS) ? 6'd24 : 6'(n));
    for (int i = 0; i < n; i++) begin
      if (i < MAX_FLITS) push_w(id, i, mk(seq, i));
      set_beat(mk(seq, i), i == 0, i == n - 1, (i == n - 1) ? emp : 6'd0);
      wait_accept();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int cnt;
    wq.delete();
    oq.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_pkt_ready, 1'b0);
    chk("rst_out_valid", out_pkt_valid, 1'b0);
    chk("rst_meta", out_meta_data, '0);
    chk("rst_wr_en", pktbuf_wr_en, 1'b0);
    chk("rst_stat_pkts", stat_pkts, '0);
    chk("rst_stat_trunc", stat_trunc, '0);
    rst = 1'b0;
    cnt = 0;
    while (!in_pkt_ready && cnt < 600) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("init_ready_cycles", 512'(cnt), 512'(PKT_NUM));
  endtask

  // Monitor: every buffer write and every accepted output beat is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (pktbuf_wr_en) begin
        if (wq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: got addr %0d want no write", pktbuf_wr_addr);
        end else begin
          we = wq.pop_front();
          chk("wr_addr", pktbuf_wr_addr, we.addr);
          chk("wr_data", pktbuf_wr_data, we.data);
        end
      end
      if (out_pkt_valid && out_ready) begin
        if (oq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got pktID %0d want no output", out_meta_data.pktID);
        end else begin
          oe = oq.pop_front();
          chk("out_sop_eop", {out_pkt_sop, out_pkt_eop, out_meta_valid}, 3'b111);
          chk("out_meta", out_meta_data, oe.meta);
          chk("out_data", out_pkt_data, oe.data);
          chk("out_empty", out_pkt_empty, oe.empty);
        end
      end
    end
  end

  initial begin
    int hi_cnt;

    // reset, then 1-flit and 3-flit packets
    do_reset();
    send_pkt(1, 1, 6'd0, 9'd0);
    send_pkt(3, 2, 6'd0, 9'd1);
    idle(2);

    // single-flit with empty=10 and one-cycle output latency
    chk("pre_out_valid", out_pkt_valid, 1'b0);
    send_pkt(1, 3, 6'd10, 9'd2);
    chk("latency_out_valid", out_pkt_valid, 1'b1);
    chk("latency_out_empty", out_pkt_empty, 6'd10);
    idle(2);

    // 30-flit packet truncated to 24
    send_pkt(30, 4, 6'd3, 9'd3);
    idle(2);
    chk("stat_pkts_4", stat_pkts, 32'd4);
    chk("stat_trunc_1", stat_trunc, 32'd1);

    // backpressure holds output and input
    out_ready = 1'b0;
    send_pkt(1, 40, 6'd0, 9'd4);
    repeat (3) @(negedge clk);
    chk("hold_in_ready", in_pkt_ready, 1'b0);
    chk("hold_out_valid", out_pkt_valid, 1'b1);
    chk("hold_out_data", out_pkt_data, mk(40, 0));
    chk("hold_out_meta", out_meta_data, mmeta(9'd4, 6'd1));
    @(posedge clk); #1;
    push_w(9'd5, 0, mk(41, 0));
    push_o(mk(41, 0), 6'd0, 9'd5, 6'd1);
    set_beat(mk(41, 0), 1'b1, 1'b1, 6'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_same_cycle_ready", in_pkt_ready, 1'b1);
    @(posedge clk); #1;
    in_pkt_valid = 1'b0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0;
    idle(2);

    // protocol errors: stray non-sop beat, then sop inside a packet
    set_beat(mk(50, 0), 1'b0, 1'b1, 6'd0);
    wait_accept();
    push_w(9'd6, 0, mk(60, 0));
    set_beat(mk(60, 0), 1'b1, 1'b0, 6'd0);
    wait_accept();
    push_o(mk(60, 0), 6'd0, 9'd6, 6'd1);
    push_w(9'd7, 0, mk(70, 0));
    set_beat(mk(70, 0), 1'b1, 1'b0, 6'd0);
    wait_accept();
    push_o(mk(70, 0), 6'd0, 9'd7, 6'd2);
    push_w(9'd7, 1, mk(70, 1));
    set_beat(mk(70, 1), 1'b0, 1'b1, 6'd5);
    wait_accept();
    idle(3);
    chk("stat_pkts_8", stat_pkts, 32'd8);

    // reset in the middle of a 5-flit packet
    push_w(9'd8, 0, mk(80, 0));
    set_beat(mk(80, 0), 1'b1, 1'b0, 6'd0);
    wait_accept();
    push_w(9'd8, 1, mk(80, 1));
    set_beat(mk(80, 1), 1'b0, 1'b0, 6'd0);
    wait_accept();
    do_reset();
    send_pkt(1, 90, 6'd0, 9'd0);

    // exhaust all IDs, stall on 513th sop, release ID 7
    for (int k = 1; k < PKT_NUM; k++) send_pkt(1, 1000 + k, 6'd0, 9'(k));
    push_w(9'd7, 0, mk(3000, 0));
    push_o(mk(3000, 0), 6'd0, 9'd7, 6'd1);
    set_beat(mk(3000, 0), 1'b1, 1'b1, 6'd0);
    hi_cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (in_pkt_ready) hi_cnt++;
    end
    chk("empty_fifo_stall", 512'(hi_cnt), '0);
    @(posedge clk); #1;
    rel_valid = 1'b1; rel_pktID = 9'd7;
    @(posedge clk); #1;
    rel_valid = 1'b0;
    wait_accept();
    idle(3);
    chk("stat_pkts_513", stat_pkts, 32'd513);
    chk("stat_trunc_0", stat_trunc, 32'd0);

    chk("wq_drained", 512'(wq.size()), '0);
    chk("oq_drained", 512'(oq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_ingress_tagger.md
Name: pkt_ingress_tagger

Overview:
- Sits directly upstream of the header parser.
- Accepts the raw 512-bit Ethernet frame stream and allocates a packet ID (pktID) from a free list.
- Writes every flit into the packet buffer at {pktID, flit index}.
- On end-of-packet, emits the first flit as a single-flit beat (sop=eop=1) together with metadata carrying pktID and flit count, which is the form the parser consumes.

Parameters:
- PKT_AWIDTH, 9, pktID width; PKT_NUM = 2**PKT_AWIDTH buffer slots.
- FLIT_AWIDTH, 5, flit-index width within a slot.
- MAX_FLITS, 24, flits stored per slot (1536 B); must be ≤ 2**FLIT_AWIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_pkt_data  in  512  frame data, network byte order
- in_pkt_valid / in_pkt_sop / in_pkt_eop  in  1 each  Avalon-ST qualifiers
- in_pkt_empty  in  6  empty bytes on eop beat
- in_pkt_ready  out  1  accept
- out_pkt_data  out  512  first flit of the packet
- out_pkt_valid / out_pkt_sop / out_pkt_eop  out  1 each  header beat (sop=eop=1)
- out_pkt_empty  out  6  in_pkt_empty if packet is one flit, else 0
- out_meta_data  out  metadata_t  pktID, flits; all other fields 0
- out_meta_valid  out  1  equals out_pkt_valid
- out_ready  in  1  downstream accept, shared by pkt and meta
- pktbuf_wr_en  out  1  buffer write strobe
- pktbuf_wr_addr  out  PKT_AWIDTH+FLIT_AWIDTH  {pktID, flit_idx}
- pktbuf_wr_data  out  512  flit
- rel_valid  in  1  slot release (always accepted)
- rel_pktID  in  PKT_AWIDTH  released ID
- stat_pkts  out  32  packets tagged
- stat_trunc  out  32  packets with more than MAX_FLITS flits

Behaviour:
- Reset:
  - All outputs 0.
  - State goes to INIT, which pushes IDs 0..PKT_NUM-1 into the free FIFO, one per cycle.
  - in_pkt_ready stays 0 for PKT_NUM cycles.
  - rst asserted mid-packet discards the packet and restarts INIT; partial buffer writes are garbage and ignored.
- States:
  - INIT → SOP after the last ID is pushed.
  - SOP → BODY on an accepted beat with sop=1 and eop=0.
  - SOP stays in SOP on an accepted sop&eop beat.
  - BODY → SOP on an accepted eop beat.
- A beat with sop=0 in SOP is consumed and dropped: no write, no count.
- A beat with sop=1 in BODY is treated as eop of the current packet followed by a new sop.
  - This is protocol error recovery; the bench checks no hang.
- in_pkt_ready = (state≠INIT) & (state==BODY | free FIFO non-empty) & (!out_valid | out_ready).
- On accepted sop:
  - Pop pktID.
  - Latch the flit into the header register.
  - flit_idx = 0.
- On each accepted beat in a packet:
  - If flit_idx < MAX_FLITS: pktbuf_wr_en=1 the same cycle (combinational from the accept), addr={pktID, flit_idx}.
  - flit_idx increments, saturating at MAX_FLITS.
  - Beats past MAX_FLITS are not written; the trunc flag is set.
- On accepted eop:
  - Load the output register next cycle: out_valid=1, meta.pktID, meta.flits = flits written (1..MAX_FLITS).
  - Header data = latched first flit, or the current beat if sop&eop.
  - stat_pkts++; stat_trunc++ if the trunc flag is set.
- Latency: eop accept at cycle N → out_valid at N+1. Output holds stable until out_ready.
- Release: rel_valid pushes rel_pktID into the free FIFO in the same cycle.
  - A simultaneous pop and push is allowed.
  - The FIFO never overflows, since it is sized PKT_NUM and IDs are unique.
  - Double release is illegal; sim assertion fires if a push hits a full FIFO.
- Free FIFO empty at sop: in_pkt_ready=0; the stream stalls without dropping.
- Counters wrap at 2**32.

Decomposition:
- Shared package (my_struct_s) holds metadata_t, PKT_AWIDTH, FLIT_AWIDTH, MAX_FLITS, and the state enum.
- One sub-module: free_id_fifo.
  - Parameterised depth PKT_NUM.
  - Register/RAM based, show-ahead read.
  - Ports: push, push_data, pop, head, empty, full.

Test Plan:
- After rst, 2 packets of 1 and 3 flits → ready rises exactly PKT_NUM cycles after rst; meta {pktID=0, flits=1} then {pktID=1, flits=3}; writes to addr 0, 32, 33, 34 (FLIT_AWIDTH=5).
- Single-flit packet with empty=10 → out_pkt_empty=10, sop=eop=1, header data equals input, out_valid exactly 1 cycle after accept.
- 30-flit packet → 24 writes (idx 0..23), meta.flits=24, stat_trunc=1.
- Tag 512 packets with no release → ready drops at the 513th sop. Release ID 7 → next packet gets pktID=7.
- Hold out_ready=0 after one packet → in_pkt_ready=0, output held stable. Raise out_ready → the next beat is accepted in the same cycle.
- Assert rst in the middle of a 5-flit packet → outputs 0, stat counters 0, INIT replays, and the next packet gets pktID=0.
